// File: rtl/fetch_stage_if.sv
// IF-stage bundle: hazard/branch controls, instruction-memory port and IF/ID register outputs.
interface fetch_stage_if #(
  parameter int unsigned PC_W = 32
);
  logic            stall;
  logic            flush;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [5:0]      imem_offset;
  logic [31:0]     imem_data;
  logic [PC_W-1:0] pc;
  logic [31:0]     if_id_inst;
  logic [PC_W-1:0] if_id_pc;
  logic [PC_W-1:0] if_id_pc4;
  logic            if_id_valid;

  modport master (
    input  stall, flush, redirect, redirect_pc, imem_data,
    output imem_offset, pc, if_id_inst, if_id_pc, if_id_pc4, if_id_valid
  );

  modport slave (
    output stall, flush, redirect, redirect_pc, imem_data,
    input  imem_offset, pc, if_id_inst, if_id_pc, if_id_pc4, if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC register, imem word offset, IF/ID pipeline register.
// Optional performance counters are compiled in with FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0033
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]    fetch_cnt,
  output logic [31:0]    stall_cnt,
  output logic [31:0]    bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ACT_REDIRECT,
    ACT_FLUSH,
    ACT_STALL,
    ACT_FETCH
  } act_e;

  act_e            act;
  logic [PC_W-1:0] pc_q, pc_d, pc_plus4;
  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] ipc_q, ipc_d;
  logic [PC_W-1:0] ipc4_q, ipc4_d;
  logic            valid_q, valid_d;

  assign pc_plus4 = pc_q + PC_W'(4);

  always_comb begin
    act = ACT_FETCH;
    if (bus.redirect)   act = ACT_REDIRECT;
    else if (bus.flush) act = ACT_FLUSH;
    else if (bus.stall) act = ACT_STALL;
  end

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    case (act)
      ACT_REDIRECT: begin
        pc_d    = bus.redirect_pc & ~PC_W'(3);
        inst_d  = NOP_INST;
        ipc_d   = '0;
        ipc4_d  = '0;
        valid_d = 1'b0;
      end
      ACT_FLUSH: begin
        // Flush+stall still bubbles IF/ID but must not advance the PC.
        if (!bus.stall) pc_d = pc_plus4;
        inst_d  = NOP_INST;
        ipc_d   = '0;
        ipc4_d  = '0;
        valid_d = 1'b0;
      end
      ACT_STALL: ;
      default: begin
        pc_d    = pc_plus4;
        inst_d  = bus.imem_data;
        ipc_d   = pc_q;
        ipc4_d  = pc_plus4;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.imem_offset = pc_q[7:2];
  assign bus.if_id_inst  = inst_q;
  assign bus.if_id_pc    = ipc_q;
  assign bus.if_id_pc4   = ipc4_q;
  assign bus.if_id_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (act == ACT_FETCH)                          fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (bus.stall && !bus.redirect)                stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (act == ACT_REDIRECT || act == ACT_FLUSH)   bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32 core. Holds the program counter, drives the word offset into the 64-entry combinational instruction memory, and registers the returned instruction with its PC into the IF/ID pipeline register. Accepts stall and flush from the hazard unit and a taken-branch redirect from the branch-resolution stage.

## Interface

- PC_W, 32, PC and address width
- RESET_PC, 32'h0000_0000, PC value on reset
- NOP_INST, 32'h0000_0033, bubble instruction (add x0, x0, x0)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  replace the IF/ID contents with a bubble
- redirect  in  1  taken branch; load redirect_pc
- redirect_pc  in  PC_W  branch target byte address
- imem_offset  out  6  word index to instruction memory, = pc[7:2]
- imem_data  in  32  instruction word from instruction memory (combinational)
- pc  out  PC_W  current fetch PC
- if_id_inst  out  32  registered instruction
- if_id_pc  out  PC_W  PC of if_id_inst
- if_id_pc4  out  PC_W  if_id_pc + 4
- if_id_valid  out  1  1 = real instruction, 0 = bubble

- Clock is `clk`. Reset is `rst_n`: asynchronous, active-low. Neither is negotiable.

## Operation

- Reset (rst_n low, any time, including mid-stall or mid-redirect):
  - pc = RESET_PC.
  - if_id_inst = NOP_INST.
  - if_id_pc = 0 and if_id_pc4 = 0.
  - if_id_valid = 0.
  - Performance counters (if compiled in) = 0.
- Each rising edge evaluates the controls in this priority order:
  1. redirect: pc <= {redirect_pc[PC_W-1:2], 2'b00}. IF/ID <= bubble (NOP_INST, valid 0, pc/pc4 = 0). stall and flush are ignored.
  2. flush: IF/ID <= bubble. pc <= pc+4 when stall=0. pc holds when stall=1.
  3. stall: pc and IF/ID all hold.
  4. Otherwise:
     - pc <= pc+4.
     - if_id_inst <= imem_data.
     - if_id_pc <= pc.
     - if_id_pc4 <= pc+4.
     - if_id_valid <= 1.
- Arithmetic:
  - pc+4 is computed modulo 2^PC_W.
  - imem_offset uses only pc[7:2], so fetch addresses alias every 256 bytes.
  - Misaligned redirect targets are silently word-aligned by clearing bits [1:0].

## Timing

- imem_offset follows the pc register combinationally. The memory returns imem_data in the same cycle.
- Latency from pc = A to if_id_inst = mem[A[7:2]] is one edge.
- First edge after rst_n deasserts with no control asserted: if_id_inst = mem[0], if_id_pc = 0, if_id_valid = 1, pc = 4.
- Redirect asserted in cycle N:
  - Edge N: bubble enters IF/ID, pc = target.
  - Edge N+1: the target instruction is in IF/ID.
  - Exactly one bubble results. Older wrong-path instructions downstream are flushed by the consumer.
- redirect held for k cycles: pc reloads the target every cycle and k bubbles are issued.
- A stall longer than one cycle holds the state with no drift in pc or IF/ID.

## Configuration

- FETCH_PERF_CNT_EN defined adds three outputs:
  - fetch_cnt, 32 bits: counts edges that load a valid instruction.
  - stall_cnt, 32 bits: counts edges with stall=1 and redirect=0.
  - bubble_cnt, 32 bits: counts edges that load a bubble.
- Counter behaviour: all three wrap at 2^32 and reset to 0.
- FETCH_PERF_CNT_EN undefined: the three ports and counters are absent, and the remaining behaviour is identical.

## Test plan

- Reset then free-run 5 cycles with the memory loaded with the q7 program:
  - if_id_inst sequence is mem[0..4].
  - if_id_pc sequence is 0, 4, 8, 12, 16.
  - valid = 1 from the first edge.
- Stall for 3 cycles at pc = 8:
  - pc stays 8 and if_id_pc stays 4 for all 3 cycles.
  - On release, if_id_pc = 8 and if_id_inst = mem[2].
- redirect = 1, redirect_pc = 0x26, while pc = 0x18:
  - Next edge: if_id_inst = 0x0000_0033, valid = 0, pc = 0x24.
  - Following edge: if_id_inst = mem[9], if_id_pc = 0x24.
- redirect, flush and stall all asserted together: redirect wins, pc = target, one bubble.
- flush + stall with pc = 0x10: bubble in IF/ID and pc stays 0x10.
- With FETCH_PERF_CNT_EN:
  - Run 10 plain fetches, 2 stall cycles and 1 redirect.
  - Required result: fetch_cnt = 10, stall_cnt = 2, bubble_cnt = 1.
  - Assert rst_n low mid-run: all three counters go to 0 immediately.
